// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Defines the response source tags and the in-flight tag record.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      SRC_NONE = 2'b00,
      SRC_I    = 2'b01,
      SRC_DRD  = 2'b10,
      SRC_DWR  = 2'b11
   } src_e;

   typedef struct packed {
      logic vld;
      src_e src;
   } tag_t;

   // Width of a counter that must hold 0..limit (at least one bit).
   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// DEPTH-deep shift register of {vld, src} tags that follows each RAM access
// until its read data appears; a synchronous clear drops everything in flight.
module mem_tag_pipe
   import mem_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk_i,
   input  logic clr_i,
   input  tag_t tag_i,
   output tag_t tag_o
);

   tag_t stage_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else begin
         stage_q[0] <= tag_i;
         for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      end
   end

   assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the CPU fetch and data ports,
// granting one access per cycle and steering each read response back to its port.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 16,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_valid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              cpu_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int               CNT_W      = cnt_width(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              fetch_first;
   tag_t              tag_in, tag_out;
   logic              i_valid_q, i_valid_d;
   logic              d_valid_q, d_valid_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   // Data wins by default (older instruction); a starved fetch takes the next conflict.
   always_comb begin
      fetch_first = i_req & (starve_cnt_q == STARVE_MAX);
      d_gnt       = ~reset & d_req & ~fetch_first;
      i_gnt       = ~reset & i_req & ~d_gnt;
      cpu_stall   = ~reset & ((i_req & ~i_gnt) | (d_req & ~d_gnt));
   end

   always_comb begin
      mem_en    = i_gnt | d_gnt;
      mem_we    = d_gnt & d_we;
      mem_addr  = d_gnt ? d_addr : i_addr;
      mem_wdata = d_wdata;
   end

   always_comb begin
      starve_cnt_d = '0;
      if (i_req & ~i_gnt) begin
         starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
      end
   end

   always_comb begin
      tag_in.vld = mem_en;
      tag_in.src = SRC_NONE;
      if (d_gnt) begin
         tag_in.src = d_we ? SRC_DWR : SRC_DRD;
      end else if (i_gnt) begin
         tag_in.src = SRC_I;
      end
   end

   mem_tag_pipe #(
      .DEPTH (MEM_LAT)
   ) u_tag_pipe (
      .clk_i (clock),
      .clr_i (reset),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );

   // The tag leaving the last stage lines up with the RAM read data.
   always_comb begin
      i_valid_d = 1'b0;
      d_valid_d = 1'b0;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      if (tag_out.vld) begin
         case (tag_out.src)
            SRC_I: begin
               i_valid_d = 1'b1;
               i_rdata_d = mem_rdata;
            end
            SRC_DRD: begin
               d_valid_d = 1'b1;
               d_rdata_d = mem_rdata;
            end
            SRC_DWR: d_valid_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt_q <= '0;
         i_valid_q    <= 1'b0;
         d_valid_q    <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         i_valid_q    <= i_valid_d;
         d_valid_q    <= d_valid_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign i_valid = i_valid_q;
   assign d_valid = d_valid_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a random phase, with a
// response scoreboard filled at grant time and drained on i_valid/d_valid.
module tb_mem_port_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          i_gnt, i_valid, d_gnt, d_valid, cpu_stall, mem_en, mem_we;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic          preload;

   always #5 clock = ~clock;

   mem_port_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .MEM_LAT      (1),
      .STARVE_LIMIT (3)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt),
      .i_valid   (i_valid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_valid   (d_valid),
      .d_rdata   (d_rdata),
      .cpu_stall (cpu_stall),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   function automatic logic [DW-1:0] word_of(input int a);
      logic [AW-1:0] b;
      b = AW'(a);
      if (a == 'h10) return 16'h1234;
      if (a == 'h20) return 16'hBEEF;
      if (a == 'h11) return 16'h5A5A;
      return {b, ~b};
   endfunction

   // Single-port RAM with one cycle of read latency.
   logic [DW-1:0] ram [256];
   always @(posedge clock) begin
      if (preload) begin
         for (int a = 0; a < 256; a++) ram[a] <= word_of(a);
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   typedef struct {
      logic [1:0]    port;   // 2'b10 = fetch, 2'b01 = data
      logic [DW-1:0] data;
      int            cyc;
   } resp_t;

   resp_t         sb[$];
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] exp_drd;
   int            cyc   = 0;
   int            n_chk = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      resp_t r;
      if (reset) begin
         sb.delete();
         exp_drd = '0;
         return;
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         chk("resp_missing_cyc", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (i_valid || d_valid) begin
         if (sb.size() == 0) begin
            chk("resp_spurious", {i_valid, d_valid}, 2'b00);
         end else begin
            r = sb.pop_front();
            chk("resp_port", {i_valid, d_valid}, r.port);
            chk("resp_cyc", cyc, r.cyc);
            if (r.port == 2'b10) chk("resp_i_rdata", i_rdata, r.data);
            else                 chk("resp_d_rdata", d_rdata, r.data);
         end
      end
      if (i_gnt) begin
         r.port = 2'b10; r.data = ref_mem[i_addr]; r.cyc = cyc + 2;
         sb.push_back(r);
      end
      if (d_gnt) begin
         if (d_we) ref_mem[d_addr] = d_wdata;
         else      exp_drd = ref_mem[d_addr];
         r.port = 2'b01; r.data = exp_drd; r.cyc = cyc + 2;
         sb.push_back(r);
      end
   endtask

   task automatic sample();
      @(negedge clock);
      monitor();
   endtask

   task automatic next();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      i_req = 1'b0;
      d_req = 1'b0;
      d_we  = 1'b0;
      for (int k = 0; k < n; k++) begin
         sample();
         next();
      end
   endtask

   logic got_i, got_d;

   initial begin
      for (int a = 0; a < 256; a++) ref_mem[a] = word_of(a);
      exp_drd = '0;
      reset = 1'b1; preload = 1'b1;
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      next();
      preload = 1'b0;

      // Reset held with both requests asserted
      for (int k = 0; k < 2; k++) begin
         sample();
         chk("rst_outs", {i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
                          cpu_stall, mem_en, mem_we, mem_addr, mem_wdata}, '0);
         next();
      end
      reset = 1'b0;
      i_req = 1'b0; d_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("idle_valids", {i_valid, d_valid}, 2'b00);
         next();
      end

      // Plain fetch
      i_req = 1'b1; i_addr = 8'h10;
      sample();
      chk("fetch_gnt", {i_gnt, d_gnt, mem_en, mem_we}, 4'b1010);
      chk("fetch_addr", mem_addr, 8'h10);
      next();
      i_req = 1'b0;
      sample();
      chk("fetch_early", i_valid, 1'b0);
      next();
      sample();
      chk("fetch_valid", i_valid, 1'b1);
      chk("fetch_rdata", i_rdata, 16'h1234);
      next();

      // Conflict: data load wins, fetch follows
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
      i_req = 1'b1; i_addr = 8'h11;
      sample();
      chk("conf_t_gnt", {i_gnt, d_gnt, cpu_stall}, 3'b011);
      chk("conf_t_addr", mem_addr, 8'h20);
      next();
      d_req = 1'b0;
      sample();
      chk("conf_t1_gnt", {i_gnt, d_gnt, cpu_stall}, 3'b100);
      chk("conf_t1_addr", mem_addr, 8'h11);
      next();
      i_req = 1'b0;
      sample();
      chk("conf_t2_valid", {i_valid, d_valid}, 2'b01);
      chk("conf_t2_drdata", d_rdata, 16'hBEEF);
      next();
      sample();
      chk("conf_t3_valid", {i_valid, d_valid}, 2'b10);
      chk("conf_t3_irdata", i_rdata, 16'h5A5A);
      next();

      // Starvation: fetch gets every 4th slot while data keeps requesting
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
      i_req = 1'b1; i_addr = 8'h31;
      for (int k = 0; k < 9; k++) begin
         sample();
         chk("starve_gnt", {i_gnt, d_gnt}, (k % 4 == 3) ? 2'b10 : 2'b01);
         chk("starve_stall", cpu_stall, 1'b1);
         next();
      end
      idle(3);

      // Store, then read it back
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h02; d_wdata = 16'h3CAB;
      sample();
      chk("store_gnt", {d_gnt, mem_en, mem_we}, 3'b111);
      chk("store_wdata", mem_wdata, 16'h3CAB);
      next();
      d_req = 1'b0; d_we = 1'b0;
      sample();
      next();
      sample();
      chk("store_valid", d_valid, 1'b1);
      chk("store_drdata_kept", d_rdata, 16'h30CF);
      next();
      d_req = 1'b1; d_addr = 8'h02;
      sample();
      next();
      d_req = 1'b0;
      sample();
      next();
      sample();
      chk("reload_valid", d_valid, 1'b1);
      chk("reload_data", d_rdata, 16'h3CAB);
      next();

      // Reset while a fetch is in flight
      i_req = 1'b1; i_addr = 8'h40;
      sample();
      chk("rif_gnt", i_gnt, 1'b1);
      next();
      i_req = 1'b0; reset = 1'b1;
      sample();
      next();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("rif_no_valid", {i_valid, d_valid}, 2'b00);
         chk("rif_rdata", {i_rdata, d_rdata}, '0);
         next();
      end

      // Random traffic; each requester holds until granted
      for (int k = 0; k < 120; k++) begin
         if (!i_req && $urandom_range(0, 1) == 1) begin
            i_req  = 1'b1;
            i_addr = AW'($urandom_range(0, 15));
         end
         if (!d_req && $urandom_range(0, 2) != 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = AW'($urandom_range(0, 15));
            d_wdata = DW'($urandom);
         end
         sample();
         if (i_req || d_req) chk("rnd_one_gnt", {1'b0, i_gnt} + {1'b0, d_gnt}, 2'd1);
         got_i = i_gnt;
         got_d = d_gnt;
         next();
         if (got_i) i_req = 1'b0;
         if (got_d) d_req = 1'b0;
      end
      idle(4);
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
